// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width/depth,
// full/empty and almost-full/almost-empty flags, occupancy count,
// overflow/underflow error pulses and a selectable read mode
// (registered read or first-word-fall-through).
module sync_fifo_param #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 16,
    parameter int ALMOST_FULL_THR  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THR = 2,
    parameter bit FWFT             = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_write,
    input  logic [DATA_WIDTH-1:0]      value_to_write,
    input  logic                       enable_read,
    output logic [DATA_WIDTH-1:0]      value_to_read,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THR);

    // Storage is deliberately not reset; the pointers alone define validity.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rd_ok, wr_ok;
    logic [CW-1:0] count_nxt;

    // A write into a full FIFO is allowed when a read frees a slot this cycle.
    always_comb begin
        rd_ok     = enable_read && !empty;
        wr_ok     = enable_write && (!full || rd_ok);
        count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= value_to_write;
    end

    // Pointers, count, flags and error pulses; flags come from the next count
    // so they line up with count in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= enable_write && !wr_ok;
            underflow    <= enable_read && !rd_ok;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head of queue is always presented; don't-care while empty.
            assign value_to_read = mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data;

            // Registered read: capture the head on an accepted read, else hold.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        rd_data <= '0;
                else if (rd_ok) rd_data <= mem[rd_ptr];
            end

            assign value_to_read = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read instance and one
// fall-through instance, both DEPTH=4, DATA_WIDTH=8, sharing clock and reset.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance (u0) signals.
    logic       we0 = 1'b0, re0 = 1'b0;
    logic [7:0] wd0 = '0, rd0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic [2:0] cnt0;

    // Fall-through instance (u1) signals.
    logic       we1 = 1'b0, re1 = 1'b0;
    logic [7:0] wd1 = '0, rd1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .enable_write(we0), .value_to_write(wd0),
        .enable_read(re0), .value_to_read(rd0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .enable_write(we1), .value_to_write(wd1),
        .enable_read(re1), .value_to_read(rd1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        n_cmp++;
        if ({empty0, ae0, full0, af0, ovf0, udf0} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 110000", {empty0, ae0, full0, af0, ovf0, udf0});
        end
        n_cmp++;
        if (cnt0 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", cnt0);
        end
        n_cmp++;
        if (rd0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %h want 00", rd0);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h07, 8'h0C, 8'h21, 8'h3F};
        for (int i = 0; i < 4; i++) begin
            we0 = 1'b1; wd0 = vals[i];
            tick();
            n_cmp++;
            if ({cnt0, full0, af0, ae0, empty0} !==
                {3'(i + 1), (i == 3), (i >= 1), (i <= 1), 1'b0}) begin
                n_err++;
                $display("FAIL fill_%0d: got cnt=%0d full=%b af=%b ae=%b empty=%b", i,
                         cnt0, full0, af0, ae0, empty0);
            end
        end
        wd0 = 8'h55;
        tick();
        n_cmp++;
        if ({ovf0, full0, cnt0} !== {1'b1, 1'b1, 3'd4}) begin
            n_err++;
            $display("FAIL overflow_pulse: got ovf=%b full=%b cnt=%0d want 1 1 4", ovf0, full0, cnt0);
        end
        we0 = 1'b0;
        tick();
        n_cmp++;
        if ({ovf0, cnt0} !== {1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL overflow_clear: got ovf=%b cnt=%0d want 0 4", ovf0, cnt0);
        end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4] = '{8'h07, 8'h0C, 8'h21, 8'h3F};
        for (int i = 0; i < 4; i++) begin
            re0 = 1'b1;
            tick();
            n_cmp++;
            if ({rd0, cnt0, af0, ae0, empty0} !==
                {vals[i], 3'(3 - i), (i <= 1), (i >= 1), (i == 3)}) begin
                n_err++;
                $display("FAIL drain_%0d: got data=%h cnt=%0d af=%b ae=%b empty=%b want data=%h",
                         i, rd0, cnt0, af0, ae0, empty0, vals[i]);
            end
        end
        re0 = 1'b0;
    endtask

    task automatic test_underflow();
        re0 = 1'b1;
        tick();
        n_cmp++;
        if ({udf0, cnt0, rd0} !== {1'b1, 3'd0, 8'h3F}) begin
            n_err++;
            $display("FAIL underflow_pulse: got udf=%b cnt=%0d data=%h want 1 0 3f", udf0, cnt0, rd0);
        end
        re0 = 1'b0;
        tick();
        n_cmp++;
        if (udf0 !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: got %b want 0", udf0);
        end
    endtask

    // Simultaneous read+write on empty: write wins, read flagged.
    task automatic test_empty_rw();
        we0 = 1'b1; wd0 = 8'h42; re0 = 1'b1;
        tick();
        n_cmp++;
        if ({udf0, cnt0, empty0, rd0} !== {1'b1, 3'd1, 1'b0, 8'h3F}) begin
            n_err++;
            $display("FAIL empty_rw: got udf=%b cnt=%0d empty=%b data=%h want 1 1 0 3f",
                     udf0, cnt0, empty0, rd0);
        end
        we0 = 1'b0;
        tick();
        n_cmp++;
        if ({rd0, cnt0, udf0} !== {8'h42, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL empty_rw_read: got data=%h cnt=%0d udf=%b want 42 0 0", rd0, cnt0, udf0);
        end
        re0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            we0 = 1'b1; wd0 = 8'hA0 + 8'(i); q.push_back(wd0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            we0 = 1'b1; re0 = 1'b1; wd0 = 8'h99 + 8'(i);
            q.push_back(wd0);
            exp = q.pop_front();
            tick();
            n_cmp++;
            if ({rd0, cnt0, full0, ovf0, udf0} !== {exp, 3'd4, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL b2b_%0d: got data=%h cnt=%0d full=%b ovf=%b want data=%h cnt=4",
                         i, rd0, cnt0, full0, ovf0, exp);
            end
        end
        we0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            re0 = 1'b1;
            exp = q.pop_front();
            tick();
            n_cmp++;
            if ({rd0, cnt0} !== {exp, 3'(3 - i)}) begin
                n_err++;
                $display("FAIL b2b_drain_%0d: got data=%h cnt=%0d want %h %0d", i, rd0, cnt0, exp, 3 - i);
            end
        end
        re0 = 1'b0;
        n_cmp++;
        if (empty0 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_empty: got %b want 1", empty0);
        end
    endtask

    task automatic test_fwft();
        we1 = 1'b1; wd1 = 8'hA5;
        tick();
        we1 = 1'b0;
        n_cmp++;
        if ({rd1, cnt1, empty1} !== {8'hA5, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL fwft_show: got data=%h cnt=%0d empty=%b want a5 1 0", rd1, cnt1, empty1);
        end
        re1 = 1'b1;
        tick();
        re1 = 1'b0;
        n_cmp++;
        if ({cnt1, empty1} !== {3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL fwft_consume: got cnt=%0d empty=%b want 0 1", cnt1, empty1);
        end
        we1 = 1'b1; wd1 = 8'h3C; tick();
        wd1 = 8'h5A; tick();
        we1 = 1'b0;
        n_cmp++;
        if (rd1 !== 8'h3C) begin
            n_err++;
            $display("FAIL fwft_head: got %h want 3c", rd1);
        end
        re1 = 1'b1;
        tick();
        n_cmp++;
        if ({rd1, cnt1} !== {8'h5A, 3'd1}) begin
            n_err++;
            $display("FAIL fwft_next: got data=%h cnt=%0d want 5a 1", rd1, cnt1);
        end
        tick();
        re1 = 1'b0;
        n_cmp++;
        if ({empty1, udf1} !== 2'b10) begin
            n_err++;
            $display("FAIL fwft_empty: got empty=%b udf=%b want 1 0", empty1, udf1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            we0 = 1'b1; wd0 = 8'h31 + 8'(i);
            tick();
        end
        we0 = 1'b0;
        n_cmp++;
        if (cnt0 !== 3'd3) begin
            n_err++;
            $display("FAIL mid_precount: got %0d want 3", cnt0);
        end
        // Mid-cycle assertion: no clock edge between here and the check.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cnt0, empty0, ae0, full0, af0, rd0} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset: got cnt=%0d empty=%b ae=%b full=%b af=%b data=%h",
                     cnt0, empty0, ae0, full0, af0, rd0);
        end
        #2 rst = 1'b0;
        we0 = 1'b1; wd0 = 8'h11;
        tick();
        we0 = 1'b0; re0 = 1'b1;
        tick();
        re0 = 1'b0;
        n_cmp++;
        if ({rd0, cnt0, empty0} !== {8'h11, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_after: got data=%h cnt=%0d empty=%b want 11 0 1", rd0, cnt0, empty0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_empty_rw();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
